decode_stage_pipe: RTL and testbench

- Parametrised MIPS-style decode stage that succeeds the fixed 32-bit decode block.
- Contains a register file with write-through bypass, opcode control decode, and branch/jump resolution in decode.
- Computes forwarding selects for execute and detects load-use and branch hazards, stalling fetch.
- Drives the D/E pipeline register with a valid/ready handshake, bubble insertion and flush.
- Sits between fetch (i_valid/o_ready, redirect feedback) and execute (o_valid/i_e_ready).

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/decode_regfile.sv | 41 ++++
 rtl/decode_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcode/funct codes, ALU op encodings,
// the control bundle carried through D/E, and forwarding-select encoding.
package decode_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU ops reuse the R-type funct codes; LUI gets its own code
  localparam logic [5:0] ALU_ADD = FN_ADD;
  localparam logic [5:0] ALU_SUB = FN_SUB;
  localparam logic [5:0] ALU_AND = FN_AND;
  localparam logic [5:0] ALU_OR  = FN_OR;
  localparam logic [5:0] ALU_LUI = 6'h0F;

  typedef struct packed {
    logic [5:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       link;
    logic       zext;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // No register write, no memory access
  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_M   = 2'd1,
    FWD_W   = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/decode_regfile.sv
// Register file with synchronous clear and write-through bypass.
// Ports: i_clk, i_rst (sync, active-high), write port i_we/i_waddr/i_wdata,
// combinational read ports i_ra/o_rda and i_rb/o_rdb. Register 0 reads 0.
module decode_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_ra,
  input  logic [AW-1:0]   i_rb,
  output logic [XLEN-1:0] o_rda,
  output logic [XLEN-1:0] o_rdb
);

  logic [XLEN-1:0] regs [NREG];

  // Storage; writes to register 0 are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Reads see a same-cycle writeback
  always_comb begin
    o_rda = regs[i_ra];
    o_rdb = regs[i_rb];
    if (i_we && (i_waddr == i_ra)) o_rda = i_wdata;
    if (i_we && (i_waddr == i_rb)) o_rdb = i_wdata;
    if (i_ra == '0) o_rda = '0;
    if (i_rb == '0) o_rdb = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register read, control decode, branch/jump resolution,
// hazard detection and the D/E pipeline register.
// Ports: fetch side i_valid/o_ready/i_instr/i_pc4/i_flush with o_redirect and
// o_target feedback; writeback i_wb_*; producer info from E (i_e_*) and M
// (i_m_*); D/E outputs o_valid, operands, immediate, rd/rt, pc4, ctrl and
// forward selects, with i_e_ready backpressure.
// Optional: DECODE_PERF_EN adds o_stall_cnt and o_bubble_cnt.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = $clog2(NREG),
  parameter int unsigned CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc4,
  input  logic            i_flush,
  input  logic            i_e_ready,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [AW-1:0]   i_e_rd,
  input  logic            i_e_regwrite,
  input  logic            i_e_memread,
  input  logic [AW-1:0]   i_m_rd,
  input  logic            i_m_regwrite,
  input  logic            i_m_memread,
  input  logic [XLEN-1:0] i_m_aluout,
  output logic            o_valid,
  output logic [XLEN-1:0] o_rs_data,
  output logic [XLEN-1:0] o_rt_data,
  output logic [XLEN-1:0] o_imm,
  output logic [AW-1:0]   o_rd,
  output logic [AW-1:0]   o_rt,
  output logic [XLEN-1:0] o_pc4,
  output ctrl_t           o_ctrl,
  output logic [1:0]      o_fa_sel,
  output logic [1:0]      o_fb_sel,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt
`endif
);

  logic [5:0]      opcode, funct;
  logic [AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] rda, rdb;
  ctrl_t           ctrl;
  logic            uses_rs, uses_rt, is_br, is_bne, is_j, is_jal, is_jr;

  assign opcode = i_instr[31:26];
  assign funct  = i_instr[5:0];
  assign rs     = AW'(i_instr[25:21]);
  assign rt     = AW'(i_instr[20:16]);
  assign rd     = AW'(i_instr[15:11]);

  decode_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_wb_we),
    .i_waddr (i_wb_addr),
    .i_wdata (i_wb_data),
    .i_ra    (rs),
    .i_rb    (rt),
    .o_rda   (rda),
    .o_rdb   (rdb)
  );

  // Control decode and source-operand usage
  always_comb begin
    ctrl    = CTRL_NOP;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_br   = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            ctrl.aluop    = funct;
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
          end
          FN_JR: begin
            uses_rs = 1'b1;
            is_jr   = 1'b1;
          end
          FN_JALR: begin
            ctrl.aluop    = ALU_ADD;
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.link     = 1'b1;
            uses_rs       = 1'b1;
            is_jr         = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.aluop    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.zext     = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_LUI: begin
        ctrl.aluop    = ALU_LUI;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.zext     = 1'b1;
      end
      OP_LW: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_SW: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.aluop = ALU_SUB;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
        is_br      = 1'b1;
        is_bne     = (opcode == OP_BNE);
      end
      OP_J: is_j = 1'b1;
      OP_JAL: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.regwrite = 1'b1;
        ctrl.link     = 1'b1;
        is_j          = 1'b1;
        is_jal        = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards against the producers currently in E and M
  logic src_e, src_e_ld, src_m_ld, load_use, br_haz, stall, adv;

  assign src_e    = (i_e_rd != '0) && ((uses_rs && (i_e_rd == rs)) || (uses_rt && (i_e_rd == rt)));
  assign src_e_ld = i_e_memread && src_e;
  assign src_m_ld = i_m_memread && (i_m_rd != '0) &&
                    ((uses_rs && (i_m_rd == rs)) || (uses_rt && (i_m_rd == rt)));
  assign load_use = src_e_ld;
  assign br_haz   = (is_br || is_jr) && ((i_e_regwrite && src_e) || src_m_ld);
  assign stall    = i_valid && (load_use || br_haz);
  assign adv      = i_e_ready || !o_valid;
  assign o_ready  = adv && !stall;

  // Branch compare operands: ALU results in M bypass the register file
  logic            m_fwd_ok, taken;
  logic [XLEN-1:0] br_a, br_b, imm_sext, imm_ext, br_target, j_target;

  assign m_fwd_ok  = i_m_regwrite && !i_m_memread && (i_m_rd != '0);
  assign br_a      = (m_fwd_ok && (i_m_rd == rs)) ? i_m_aluout : rda;
  assign br_b      = (m_fwd_ok && (i_m_rd == rt)) ? i_m_aluout : rdb;
  assign taken     = is_br && ((br_a == br_b) ^ is_bne);

  assign imm_sext  = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};
  assign imm_ext   = ctrl.zext ? XLEN'(i_instr[15:0]) : imm_sext;
  assign br_target = i_pc4 + {imm_sext[XLEN-3:0], 2'b00};
  assign j_target  = {i_pc4[XLEN-1:28], i_instr[25:0], 2'b00};

  assign o_target   = is_j ? j_target : (is_jr ? br_a : br_target);
  assign o_redirect = !i_rst && i_valid && o_ready && !i_flush && (taken || is_j || is_jr);

  // Forward selects as seen once E/M producers have moved to M/W
  fwd_sel_e        fa_sel, fb_sel;
  logic [AW-1:0]   dst;

  always_comb begin
    fa_sel = FWD_REG;
    fb_sel = FWD_REG;
    if (i_e_regwrite && (i_e_rd == rs) && (rs != '0))      fa_sel = FWD_M;
    else if (i_m_regwrite && (i_m_rd == rs) && (rs != '0)) fa_sel = FWD_W;
    if (i_e_regwrite && (i_e_rd == rt) && (rt != '0))      fb_sel = FWD_M;
    else if (i_m_regwrite && (i_m_rd == rt) && (rt != '0)) fb_sel = FWD_W;
  end

  always_comb begin
    dst = rt;
    if (is_jal)           dst = '1;
    else if (ctrl.regdst) dst = rd;
  end

  // D/E pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm     <= '0;
      o_rd      <= '0;
      o_rt      <= '0;
      o_pc4     <= '0;
      o_ctrl    <= CTRL_NOP;
      o_fa_sel  <= 2'b00;
      o_fb_sel  <= 2'b00;
    end else if (adv) begin
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (stall || !i_valid) begin
        o_valid <= 1'b0;
        o_ctrl  <= CTRL_NOP;
      end else begin
        o_valid   <= 1'b1;
        o_rs_data <= rda;
        o_rt_data <= rdb;
        o_imm     <= imm_ext;
        o_rd      <= dst;
        o_rt      <= rt;
        o_pc4     <= i_pc4;
        o_ctrl    <= ctrl;
        o_fa_sel  <= fa_sel;
        o_fb_sel  <= fb_sel;
      end
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end
  end

`ifdef DECODE_PERF_EN
  logic bubble_load;
  assign bubble_load = adv && !i_flush && (stall || !i_valid);

  // Saturating stall/bubble counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (stall && (o_stall_cnt != '1))        o_stall_cnt  <= o_stall_cnt + CNT_W'(1);
      if (bubble_load && (o_bubble_cnt != '1)) o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe (default build, XLEN=32, NREG=32).
module tb_decode_stage_pipe;
  import decode_pkg::*;

  logic        i_clk, i_rst, i_valid, o_ready, i_flush, i_e_ready;
  logic [31:0] i_instr, i_pc4, i_wb_data, i_m_aluout;
  logic        i_wb_we, i_e_regwrite, i_e_memread, i_m_regwrite, i_m_memread;
  logic [4:0]  i_wb_addr, i_e_rd, i_m_rd, o_rd, o_rt;
  logic        o_valid, o_redirect;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4, o_target;
  ctrl_t       o_ctrl;
  logic [1:0]  o_fa_sel, o_fb_sel;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc4(i_pc4), .i_flush(i_flush), .i_e_ready(i_e_ready),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_e_rd(i_e_rd), .i_e_regwrite(i_e_regwrite), .i_e_memread(i_e_memread),
    .i_m_rd(i_m_rd), .i_m_regwrite(i_m_regwrite), .i_m_memread(i_m_memread),
    .i_m_aluout(i_m_aluout), .o_valid(o_valid), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm(o_imm), .o_rd(o_rd), .o_rt(o_rt),
    .o_pc4(o_pc4), .o_ctrl(o_ctrl), .o_fa_sel(o_fa_sel), .o_fb_sel(o_fb_sel),
    .o_redirect(o_redirect), .o_target(o_target)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    i_wb_we = 1'b1; i_wb_addr = addr; i_wb_data = data;
    tick();
    i_wb_we = 1'b0;
  endtask

  task automatic clear_em();
    i_e_rd = 0; i_e_regwrite = 0; i_e_memread = 0;
    i_m_rd = 0; i_m_regwrite = 0; i_m_memread = 0; i_m_aluout = 0;
  endtask

  initial begin
    i_rst = 1; i_valid = 1; i_flush = 0; i_e_ready = 1;
    i_instr = jtype(6'h02, 26'h100); i_pc4 = 32'h10;
    i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
    clear_em();

    // Reset: registered outputs cleared, redirect suppressed
    tick(); tick();
    chk("rst_redirect", o_redirect, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_rs_data", o_rs_data, 0);
    chk("rst_pc4", o_pc4, 0);
    i_rst = 0; i_valid = 0;

    wb_write(5'd3, 32'h10);
    wb_write(5'd6, 32'h6);

    // W bypass
    i_wb_we = 1; i_wb_addr = 7; i_wb_data = 32'hDEAD;
    i_valid = 1; i_instr = rtype(5'd7, 5'd0, 5'd1, 6'h20); i_pc4 = 32'h200;
    #1 chk("byp_ready", o_ready, 1);
    tick();
    i_wb_we = 0;
    chk("byp_valid", o_valid, 1);
    chk("byp_rs_data", o_rs_data, 32'hDEAD);
    chk("byp_rt_data", o_rt_data, 0);
    chk("byp_rd", o_rd, 1);
    chk("byp_pc4", o_pc4, 32'h200);
    chk("byp_regwrite", o_ctrl.regwrite, 1);
    chk("byp_fa", o_fa_sel, 0);
    i_instr = rtype(5'd7, 5'd3, 5'd2, 6'h20);
    tick();
    chk("rf_rs_r7", o_rs_data, 32'hDEAD);
    chk("rf_rt_r3", o_rt_data, 32'h10);

    // Register 0 ignores writes, including the same-cycle bypass
    i_wb_we = 1; i_wb_addr = 0; i_wb_data = 32'hFFFF;
    i_instr = rtype(5'd0, 5'd0, 5'd1, 6'h20);
    tick();
    i_wb_we = 0;
    chk("r0_bypass", o_rs_data, 0);
    tick();
    chk("r0_read", o_rs_data, 0);

    // Load-use: one stall, a bubble, then issue with select from W
    i_e_memread = 1; i_e_regwrite = 1; i_e_rd = 5;
    i_instr = rtype(5'd5, 5'd6, 5'd3, 6'h20);
    #1 chk("lu_ready", o_ready, 0);
    tick();
    chk("lu_bubble", o_valid, 0);
    chk("lu_bubble_ctrl", o_ctrl.regwrite, 0);
    clear_em();
    i_m_rd = 5; i_m_regwrite = 1; i_m_memread = 1;
    #1 chk("lu_ready2", o_ready, 1);
    tick();
    chk("lu_valid", o_valid, 1);
    chk("lu_fa", o_fa_sel, 2);
    chk("lu_fb", o_fb_sel, 0);
    chk("lu_rt_data", o_rt_data, 6);

    // Forward-select priority: E beats M
    clear_em();
    i_e_regwrite = 1; i_e_rd = 5; i_m_regwrite = 1; i_m_rd = 5;
    tick();
    chk("fwd_e_prio", o_fa_sel, 1);
    i_e_rd = 6;
    tick();
    chk("fwd_fa_m", o_fa_sel, 2);
    chk("fwd_fb_e", o_fb_sel, 1);

    // Branch operand forwarded from M
    clear_em();
    i_m_regwrite = 1; i_m_rd = 2; i_m_aluout = 32'h10;
    i_instr = itype(6'h04, 5'd2, 5'd3, 16'd4); i_pc4 = 32'h100;
    #1;
    chk("beq_ready", o_ready, 1);
    chk("beq_redirect", o_redirect, 1);
    chk("beq_target", o_target, 32'h110);
    i_instr = itype(6'h05, 5'd2, 5'd3, 16'd4);
    #1 chk("bne_redirect", o_redirect, 0);
    i_instr = itype(6'h04, 5'd3, 5'd3, 16'hFFFF);
    #1;
    chk("beq_neg_redirect", o_redirect, 1);
    chk("beq_neg_target", o_target, 32'hFC);
    tick();
    // Branch hazard on an ALU producer in E
    i_e_regwrite = 1; i_e_rd = 2;
    i_instr = itype(6'h04, 5'd2, 5'd3, 16'd4);
    #1;
    chk("brhaz_ready", o_ready, 0);
    chk("brhaz_redirect", o_redirect, 0);
    tick();
    chk("brhaz_bubble", o_valid, 0);

    // JAL
    clear_em();
    i_instr = jtype(6'h03, 26'h100); i_pc4 = 32'h0040_0004;
    #1;
    chk("jal_redirect", o_redirect, 1);
    chk("jal_target", o_target, 32'h400);
    tick();
    chk("jal_rd", o_rd, 31);
    chk("jal_link", o_ctrl.link, 1);
    chk("jal_valid", o_valid, 1);

    // Immediate extension
    i_instr = itype(6'h0C, 5'd3, 5'd4, 16'h8000);
    tick();
    chk("andi_imm", o_imm, 32'h0000_8000);
    chk("andi_rd", o_rd, 4);
    chk("andi_rt", o_rt, 4);
    i_instr = itype(6'h08, 5'd3, 5'd4, 16'h8000);
    tick();
    chk("addi_imm", o_imm, 32'hFFFF_8000);
    chk("addi_rs", o_rs_data, 32'h10);

    // Backpressure holds D/E, then flush clears it without redirect
    i_e_ready = 0;
    i_instr = rtype(5'd7, 5'd0, 5'd1, 6'h20);
    #1 chk("bp_ready", o_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", o_valid, 1);
      chk("bp_hold_imm", o_imm, 32'hFFFF_8000);
    end
    i_flush = 1; i_instr = jtype(6'h02, 26'h40);
    #1 chk("flush_redirect", o_redirect, 0);
    tick();
    chk("flush_valid", o_valid, 0);
    i_flush = 0; i_e_ready = 1;

    // Unknown opcode issues as a NOP
    i_instr = {6'h3F, 26'h3FF_FFFF};
    tick();
    chk("unk_valid", o_valid, 1);
    chk("unk_regwrite", o_ctrl.regwrite, 0);
    chk("unk_memwrite", o_ctrl.memwrite, 0);
    chk("unk_memread", o_ctrl.memread, 0);

    // Reset mid-stall clears pipeline and registers
    i_e_memread = 1; i_e_regwrite = 1; i_e_rd = 5;
    i_instr = rtype(5'd5, 5'd6, 5'd3, 6'h20);
    i_rst = 1;
    tick();
    chk("rst2_valid", o_valid, 0);
    i_rst = 0;
    clear_em();
    i_instr = rtype(5'd7, 5'd3, 5'd1, 6'h20);
    tick();
    chk("rst2_issue", o_valid, 1);
    chk("rst2_rs_clr", o_rs_data, 0);
    chk("rst2_rt_clr", o_rt_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
